// File: rtl/fsm_driver_pkg.sv
// rtl/fsm_driver_pkg.sv - shared types and constants for the peer FSM driver
package fsm_driver_pkg;

    localparam int CNT_W           = 8;
    localparam int HOLD_CYC_DEF    = 2;
    localparam int TIMEOUT_CYC_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COIN      = 3'd1,
        ST_WAIT_UNLK = 3'd2,
        ST_START     = 3'd3,
        ST_WAIT_LOCK = 3'd4
    } state_t;

endpackage

// File: rtl/fsm_driver_if.sv
// rtl/fsm_driver_if.sv - request/peer handshake bundle for the FSM driver
interface fsm_driver_if;
    import fsm_driver_pkg::*;

    logic             req;
    logic             abort;
    logic             lock;
    logic             unlock;
    logic             coin;
    logic             start;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] txn_cnt;

    modport master (
        output req, abort, lock, unlock,
        input  coin, start, busy, done, err, txn_cnt
    );

    modport slave (
        input  req, abort, lock, unlock,
        output coin, start, busy, done, err, txn_cnt
    );

endinterface

// File: rtl/fsm_driver_cyc_timer.sv
// rtl/fsm_driver_cyc_timer.sv - loadable saturating down-counter with expiry flag
module cyc_timer
    import fsm_driver_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load wins over counting so a new phase always starts from a full count.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/fsm_driver.sv
// rtl/fsm_driver.sv - drives a coin/start peer and waits for its unlock/lock replies
module fsm_driver
    import fsm_driver_pkg::*;
#(
    parameter bit MEALY_FSM   = 1'b0,
    parameter int HOLD_CYC    = HOLD_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    fsm_driver_if.slave bus
);

    if (HOLD_CYC < 1 || HOLD_CYC > 15 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255 ||
        (MEALY_FSM != 1'b0 && MEALY_FSM != 1'b1)) begin : g_bad_param
        $error("fsm_driver: parameter out of range");
    end

    state_t           state_q, state_d;
    logic             coin_q, coin_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             flag_q, flag_d;
    logic [CNT_W-1:0] txn_q, txn_d;

    logic fin_ok, fin_err;
    logic phase1, phase_load;
    logic hold_en, tmo_en;
    logic hold_exp, tmo_exp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            coin_q  <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            flag_q  <= 1'b0;
            txn_q   <= '0;
        end else begin
            state_q <= state_d;
            coin_q  <= coin_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            flag_q  <= flag_d;
            txn_q   <= txn_d;
        end
    end

    // Abort beats a protocol error, which beats every phase event; within a
    // wait state a reply (sticky or same-cycle) beats the timeout.
    always_comb begin
        state_d = state_q;
        fin_ok  = 1'b0;
        fin_err = 1'b0;
        if (state_q != ST_IDLE && bus.abort) begin
            state_d = ST_IDLE;
        end else if (state_q != ST_IDLE && bus.lock && bus.unlock) begin
            state_d = ST_IDLE;
            fin_err = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE:      if (bus.req) state_d = ST_COIN;
                ST_COIN:      if (hold_exp) state_d = ST_WAIT_UNLK;
                ST_WAIT_UNLK: begin
                    if (flag_q || bus.unlock) begin
                        state_d = ST_START;
                    end else if (tmo_exp) begin
                        state_d = ST_IDLE;
                        fin_err = 1'b1;
                    end
                end
                ST_START:     if (hold_exp) state_d = ST_WAIT_LOCK;
                ST_WAIT_LOCK: begin
                    if (flag_q || bus.lock) begin
                        state_d = ST_IDLE;
                        fin_ok  = 1'b1;
                    end else if (tmo_exp) begin
                        state_d = ST_IDLE;
                        fin_err = 1'b1;
                    end
                end
                default:      state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so coin/start never see a
    // combinational path from the peer's replies.
    always_comb begin
        phase1     = (state_q == ST_COIN) || (state_q == ST_WAIT_UNLK);
        phase_load = ((state_d == ST_COIN)  && (state_q != ST_COIN)) ||
                     ((state_d == ST_START) && (state_q != ST_START));
        hold_en    = (state_q == ST_COIN) || (state_q == ST_START);
        tmo_en     = (state_q != ST_IDLE);
        coin_d     = (state_d == ST_COIN);
        start_d    = (state_d == ST_START);
        busy_d     = (state_d != ST_IDLE);
        done_d     = fin_ok;
        err_d      = fin_err;
        txn_d      = fin_ok ? txn_q + 1'b1 : txn_q;
        if (phase_load || (state_d == ST_IDLE)) begin
            flag_d = 1'b0;
        end else begin
            flag_d = flag_q | (phase1 ? bus.unlock : bus.lock);
        end
    end

    cyc_timer u_hold (
        .clk      (clk),
        .rst      (rst),
        .load     (phase_load),
        .load_val (CNT_W'(HOLD_CYC - 1)),
        .en       (hold_en),
        .expired  (hold_exp)
    );

    cyc_timer u_tmo (
        .clk      (clk),
        .rst      (rst),
        .load     (phase_load),
        .load_val (CNT_W'(TIMEOUT_CYC - 1)),
        .en       (tmo_en),
        .expired  (tmo_exp)
    );

    assign bus.coin    = coin_q;
    assign bus.start   = start_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.txn_cnt = txn_q;

endmodule

// File: tb/tb_fsm_driver.sv
// tb/tb_fsm_driver.sv - directed and randomized checks of fsm_driver against a transaction timeline model
module tb_fsm_driver;
    import fsm_driver_pkg::*;

    localparam int H = 2;
    localparam int T = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fsm_driver_if bus();

    fsm_driver #(.MEALY_FSM(1'b0), .HOLD_CYC(H), .TIMEOUT_CYC(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Peer: 0 = scripted pulses, 1 = Mealy (same-cycle reply), 2 = Moore (next-cycle reply)
    int   peer_mode = 0;
    logic unlock_drv = 1'b0;
    logic lock_drv   = 1'b0;
    logic unl_r = 1'b0;
    logic lck_r = 1'b0;

    always @(posedge clk) begin
        unl_r <= bus.coin;
        lck_r <= bus.start;
    end

    assign bus.unlock = (peer_mode == 1) ? bus.coin  : (peer_mode == 2) ? unl_r : unlock_drv;
    assign bus.lock   = (peer_mode == 1) ? bus.start : (peer_mode == 2) ? lck_r : lock_drv;

    int checks    = 0;
    int failures  = 0;
    int model_cnt = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input bit c, input bit s, input bit b,
                              input bit d, input bit e, input int cnt);
        chk({tag, ".coin"},    {7'b0, bus.coin},  {7'b0, c});
        chk({tag, ".start"},   {7'b0, bus.start}, {7'b0, s});
        chk({tag, ".busy"},    {7'b0, bus.busy},  {7'b0, b});
        chk({tag, ".done"},    {7'b0, bus.done},  {7'b0, d});
        chk({tag, ".err"},     {7'b0, bus.err},   {7'b0, e});
        chk({tag, ".txn_cnt"}, bus.txn_cnt,       cnt[7:0]);
    endtask

    // Timeline model. Cycle 1 is the first COIN cycle. A phase holds its pulse
    // for H cycles, then waits; it succeeds at the first cycle >= H+1 at which
    // the reply has been seen, and times out at cycle max(T, H+1) of the phase.
    // u/l: first reply cycle within each phase (0 = never); a_sel: -1 random
    // abort, 0 none, >0 abort cycle; p: cycle with lock and unlock both high.
    task automatic run_txn(input string tag, input int u, input int l, input int a_sel, input int p);
        int  tt, end1, s2, end2, len, a;
        bit  ok1, ok2, dn, er;
        tt  = (T > H + 1) ? T : H + 1;
        ok1 = (u != 0) && (u <= tt);
        end1 = ok1 ? ((u > H + 1) ? u : H + 1) : tt;
        s2  = end1 + 1;
        ok2 = ok1 && (l != 0) && (l <= tt);
        end2 = s2 - 1 + (ok2 ? ((l > H + 1) ? l : H + 1) : tt);
        if (ok1) begin
            len = end2 + 1;
            dn  = ok2;
            er  = !ok2;
        end else begin
            len = end1 + 1;
            dn  = 1'b0;
            er  = 1'b1;
        end
        if (p != 0 && p < len) begin
            len = p + 1;
            dn  = 1'b0;
            er  = 1'b1;
        end
        a = a_sel;
        if (a_sel < 0) a = ($urandom_range(3) == 0) ? int'($urandom_range(len - 1, 1)) : 0;
        if (a > 0 && a < len) begin
            len = a + 1;
            dn  = 1'b0;
            er  = 1'b0;
        end

        bus.req = 1'b1;
        for (int c = 1; c <= len; c++) begin
            bit b;
            @(posedge clk);
            #1;
            b = (c < len);
            check_outs(tag, b && (c <= H), b && ok1 && (c >= s2) && (c < s2 + H), b,
                       (c == len) && dn, (c == len) && er,
                       ((c == len) && dn) ? (model_cnt + 1) % 256 : model_cnt);
            bus.req    = 1'b0;
            bus.abort  = (c < len) && (c == a);
            unlock_drv = (c < len) && (((c == u) && (c <= end1)) || (c == p));
            lock_drv   = (c < len) && ((ok1 && (l != 0) && (c == s2 + l - 1)) || (c == p));
        end
        if (dn) model_cnt = (model_cnt + 1) % 256;
    endtask

    initial begin
        rst = 1'b1;
        bus.req   = 1'b0;
        bus.abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        rst = 1'b0;

        peer_mode = 2;
        run_txn("moore", 2, 2, 0, 0);
        peer_mode = 1;
        run_txn("mealy", 1, 1, 0, 0);
        peer_mode = 0;
        run_txn("timeout", 0, 0, 0, 0);

        peer_mode = 2;
        run_txn("abort_start", 2, 2, 4, 0);
        run_txn("after_abort", 2, 2, 0, 0);

        peer_mode = 0;
        run_txn("tie_success", T, T, 0, 0);
        run_txn("proto_err", 0, 0, 0, 3);

        peer_mode = 1;
        bus.req = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_coin.coin", {7'b0, bus.coin}, 8'd1);
        bus.req = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_outs("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_cnt = 0;

        for (int i = 0; i < 256; i++) run_txn("b2b", 1, 1, 0, 0);
        chk("wrap.txn_cnt", bus.txn_cnt, 8'd0);

        peer_mode = 0;
        for (int i = 0; i < 40; i++) begin
            run_txn("rand", int'($urandom_range(T + 3, 0)), int'($urandom_range(T + 3, 0)), -1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
